// File: rtl/data_sram_arb_pkg.sv
// Shared types for the data SRAM arbiter.
//   mem_size_e : access size encoding carried on pN_size
//   resp_t     : response register captured on every grant, replayed one
//                cycle later as data_ok / err / rdata on the owning port
package data_sram_arb_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSV  = 2'd3
  } mem_size_e;

  // Width of the starvation counter; wide enough for STARVE_MAX up to 15.
  localparam int STARVE_CNT_W = 4;

  typedef struct packed {
    logic      vld;
    logic      port;  // 0 = EXE load/store, 1 = aux/debug
    logic      wr;
    mem_size_e size;
    logic [1:0] off;
    logic      err;
  } resp_t;

endpackage

// File: rtl/data_sram_arb_mem_align.sv
// Lane formatting between a 32-bit byte-addressed requester and a
// word-wide SRAM. Purely combinational.
// Ports:
//   i_size, i_off, i_wdata -> o_we (byte strobes), o_wdata (lane-replicated),
//                             o_misalign (reserved size or unaligned offset)
//   i_rsize, i_roff, i_rdata -> o_rdata (right-justified, zero-extended)
module data_sram_arb_mem_align
  import data_sram_arb_pkg::*;
(
  input  mem_size_e   i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  input  mem_size_e   i_rsize,
  input  logic [1:0]  i_roff,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;

  // NOTE: every output of a combinational block gets a default before the
  // case, otherwise an uncovered path would infer a latch.
  always_comb begin
    o_we       = 4'b0000;
    o_wdata    = i_wdata;
    o_misalign = 1'b0;
    unique case (i_size)
      SZ_BYTE: begin
        o_we    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_we       = 4'b0011 << i_off;
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_off[0];
      end
      SZ_WORD: begin
        o_we       = 4'b1111;
        o_misalign = |i_off;
      end
      default: o_misalign = 1'b1;
    endcase
  end

  // Bring the addressed lane down to bit 0, then mask to the access size.
  assign w_shift = i_rdata >> {i_roff, 3'b000};

  always_comb begin
    o_rdata = w_shift;
    unique case (i_rsize)
      SZ_BYTE: o_rdata = {24'h0, w_shift[7:0]};
      SZ_HALF: o_rdata = {16'h0, w_shift[15:0]};
      default: o_rdata = w_shift;
    endcase
  end

endmodule

// File: rtl/data_sram_arb.sv
// Two-port arbiter in front of a single synchronous data SRAM.
// Port 0 (EXE load/store) has fixed priority; port 1 (aux/debug) is forced
// through after STARVE_MAX consecutive losses. Every granted access
// completes exactly one cycle later on its own port.
// Ports:
//   clk, reset                     clock, async active-high reset
//   pN_req/wr/size/addr/wdata      request side, N = 0,1
//   pN_addr_ok                     accepted this cycle
//   pN_data_ok/rdata/err           completion, one cycle after addr_ok
//   sram_en/we/addr/wdata          SRAM command, sram_rdata one cycle later
module data_sram_arb
  import data_sram_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_wr,
  input  logic [1:0]  p0_size,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_addr_ok,
  output logic        p0_data_ok,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_wr,
  input  logic [1:0]  p1_size,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_addr_ok,
  output logic        p1_data_ok,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

  resp_t                   r_resp;
  logic [STARVE_CNT_W-1:0] r_starve_cnt;

  logic        w_force1;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_any;
  logic        w_sel_wr;
  mem_size_e   w_sel_size;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_we;
  logic [31:0] w_wdata;
  logic        w_misalign;
  logic [31:0] w_rdata;
  logic [31:0] w_load_data;

  // Port 1 wins a conflict only once it has lost STARVE_MAX times in a row.
  // Grants are suppressed while reset is high.
  assign w_force1 = p1_req && (r_starve_cnt == CNT_MAX);
  assign w_grant0 = !reset && p0_req && !w_force1;
  assign w_grant1 = !reset && p1_req && !w_grant0;
  assign w_any    = w_grant0 || w_grant1;

  assign w_sel_wr    = w_grant1 ? p1_wr    : p0_wr;
  assign w_sel_size  = mem_size_e'(w_grant1 ? p1_size : p0_size);
  assign w_sel_addr  = w_grant1 ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_grant1 ? p1_wdata : p0_wdata;

  data_sram_arb_mem_align u_align (
    .i_size     (w_sel_size),
    .i_off      (w_sel_addr[1:0]),
    .i_wdata    (w_sel_wdata),
    .o_we       (w_we),
    .o_wdata    (w_wdata),
    .o_misalign (w_misalign),
    .i_rsize    (r_resp.size),
    .i_roff     (r_resp.off),
    .i_rdata    (sram_rdata),
    .o_rdata    (w_rdata)
  );

  assign p0_addr_ok = w_grant0;
  assign p1_addr_ok = w_grant1;

  // A misaligned access is acknowledged but never reaches the SRAM.
  assign sram_en    = w_any && !w_misalign;
  assign sram_we    = (sram_en && w_sel_wr) ? w_we : 4'b0000;
  assign sram_addr  = {w_sel_addr[31:2], 2'b00};
  assign sram_wdata = w_wdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp       <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_resp.vld  <= w_any;
      r_resp.port <= w_grant1;
      r_resp.wr   <= w_sel_wr;
      r_resp.size <= w_sel_size;
      r_resp.off  <= w_sel_addr[1:0];
      r_resp.err  <= w_misalign;
      if (w_grant0 && p1_req) begin
        if (r_starve_cnt != CNT_MAX) r_starve_cnt <= r_starve_cnt + 1'b1;
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

  // Stores and faulted loads return zero.
  assign w_load_data = (!r_resp.wr && !r_resp.err) ? w_rdata : 32'h0;

  assign p0_data_ok = r_resp.vld && !r_resp.port;
  assign p1_data_ok = r_resp.vld &&  r_resp.port;
  assign p0_err     = p0_data_ok && r_resp.err;
  assign p1_err     = p1_data_ok && r_resp.err;
  assign p0_rdata   = p0_data_ok ? w_load_data : 32'h0;
  assign p1_rdata   = p1_data_ok ? w_load_data : 32'h0;

endmodule

// File: tb/tb_data_sram_arb.sv
// Directed bench for data_sram_arb (STARVE_MAX = 4). Inputs change 1 ns
// after the rising edge, outputs are sampled 1 ns later.
module tb_data_sram_arb;

  logic        clk;
  logic        reset;
  logic        p0_req, p0_wr, p1_req, p1_wr;
  logic [1:0]  p0_size, p1_size;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_addr_ok, p0_data_ok, p0_err;
  logic        p1_addr_ok, p1_data_ok, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  data_sram_arb #(.STARVE_MAX(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .p0_req     (p0_req),
    .p0_wr      (p0_wr),
    .p0_size    (p0_size),
    .p0_addr    (p0_addr),
    .p0_wdata   (p0_wdata),
    .p0_addr_ok (p0_addr_ok),
    .p0_data_ok (p0_data_ok),
    .p0_rdata   (p0_rdata),
    .p0_err     (p0_err),
    .p1_req     (p1_req),
    .p1_wr      (p1_wr),
    .p1_size    (p1_size),
    .p1_addr    (p1_addr),
    .p1_wdata   (p1_wdata),
    .p1_addr_ok (p1_addr_ok),
    .p1_data_ok (p1_data_ok),
    .p1_rdata   (p1_rdata),
    .p1_err     (p1_err),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  task automatic drive0(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d);
    p0_req = 1'b1; p0_wr = wr; p0_size = sz; p0_addr = a; p0_wdata = d;
  endtask

  task automatic drive1(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d);
    p1_req = 1'b1; p1_wr = wr; p1_size = sz; p1_addr = a; p1_wdata = d;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    p0_wr = 1'b0; p0_size = 2'd0; p0_addr = '0; p0_wdata = '0;
    p1_wr = 1'b0; p1_size = 2'd0; p1_addr = '0; p1_wdata = '0;
    sram_rdata = '0;

    // Reset: a pending request must not be acknowledged.
    drive0(1'b1, 2'd2, 32'h10, 32'h1);
    #2;
    check_bit("rst_addr_ok", p0_addr_ok, 1'b0);
    check_bit("rst_sram_en", sram_en, 1'b0);
    check_word("rst_sram_we", {28'h0, sram_we}, 32'h0);
    check_bit("rst_data_ok", p0_data_ok, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    idle();
    tick();

    // 1: byte store to lane 3.
    drive0(1'b1, 2'd0, 32'h1003, 32'hAB);
    #1;
    check_bit("t1_addr_ok", p0_addr_ok, 1'b1);
    check_bit("t1_p1_addr_ok", p1_addr_ok, 1'b0);
    check_bit("t1_sram_en", sram_en, 1'b1);
    check_word("t1_sram_addr", sram_addr, 32'h1000);
    check_word("t1_sram_we", {28'h0, sram_we}, 32'h8);
    check_word("t1_sram_wdata", sram_wdata, 32'hABABABAB);
    tick();
    idle();
    #1;
    check_bit("t1_data_ok", p0_data_ok, 1'b1);
    check_bit("t1_err", p0_err, 1'b0);
    check_word("t1_rdata", p0_rdata, 32'h0);
    tick();

    // 2: half load from upper half.
    drive0(1'b0, 2'd1, 32'h2002, 32'h0);
    #1;
    check_bit("t2_addr_ok", p0_addr_ok, 1'b1);
    check_word("t2_sram_we", {28'h0, sram_we}, 32'h0);
    check_word("t2_sram_addr", sram_addr, 32'h2000);
    tick();
    idle();
    sram_rdata = 32'hBEEF1234;
    #1;
    check_bit("t2_data_ok", p0_data_ok, 1'b1);
    check_word("t2_rdata", p0_rdata, 32'h0000BEEF);
    tick();

    // 3: simultaneous requests with a cleared counter.
    drive0(1'b0, 2'd2, 32'h100, 32'h0);
    drive1(1'b0, 2'd2, 32'h40, 32'h0);
    #1;
    check_bit("t3_p0_addr_ok", p0_addr_ok, 1'b1);
    check_bit("t3_p1_addr_ok", p1_addr_ok, 1'b0);
    check_word("t3_sram_addr", sram_addr, 32'h100);
    tick();
    idle();
    sram_rdata = 32'h11223344;
    #1;
    check_bit("t3_p0_data_ok", p0_data_ok, 1'b1);
    check_bit("t3_p1_data_ok", p1_data_ok, 1'b0);
    check_word("t3_rdata", p0_rdata, 32'h11223344);
    tick();

    // 4: starvation; p1 wins on cycles 5 and 10.
    drive0(1'b0, 2'd2, 32'h100, 32'h0);
    drive1(1'b0, 2'd2, 32'h40, 32'h0);
    sram_rdata = 32'hCAFEF00D;
    for (int c = 1; c <= 10; c++) begin
      #1;
      check_bit($sformatf("t4_p0_addr_ok_c%0d", c), p0_addr_ok, !(c == 5 || c == 10));
      check_bit($sformatf("t4_p1_addr_ok_c%0d", c), p1_addr_ok, (c == 5 || c == 10));
      if (c >= 2) begin
        check_bit($sformatf("t4_p0_data_ok_c%0d", c), p0_data_ok, c != 6);
        check_bit($sformatf("t4_p1_data_ok_c%0d", c), p1_data_ok, c == 6);
      end
      if (c == 6) check_word("t4_p1_rdata", p1_rdata, 32'hCAFEF00D);
      tick();
    end
    idle();
    #1;
    check_bit("t4_last_p1_data_ok", p1_data_ok, 1'b1);
    check_bit("t4_last_p0_data_ok", p0_data_ok, 1'b0);
    tick();

    // Back-to-back on different ports: p1 byte load, then p0 half store.
    drive1(1'b0, 2'd0, 32'h41, 32'h0);
    #1;
    check_bit("bb_p1_addr_ok", p1_addr_ok, 1'b1);
    check_word("bb_sram_addr", sram_addr, 32'h40);
    tick();
    idle();
    drive0(1'b1, 2'd1, 32'h2002, 32'h5678);
    sram_rdata = 32'hCAFEF00D;
    #1;
    check_bit("bb_p1_data_ok", p1_data_ok, 1'b1);
    check_word("bb_p1_rdata", p1_rdata, 32'h000000F0);
    check_bit("bb_p0_addr_ok", p0_addr_ok, 1'b1);
    check_word("bb_sram_we", {28'h0, sram_we}, 32'hC);
    check_word("bb_sram_wdata", sram_wdata, 32'h56785678);
    tick();
    idle();
    #1;
    check_bit("bb_p0_data_ok", p0_data_ok, 1'b1);
    check_bit("bb_p1_data_ok_off", p1_data_ok, 1'b0);
    check_word("bb_p0_rdata", p0_rdata, 32'h0);
    tick();

    // 5: misaligned word store from p1.
    drive1(1'b1, 2'd2, 32'h3002, 32'h12345678);
    #1;
    check_bit("t5_addr_ok", p1_addr_ok, 1'b1);
    check_bit("t5_sram_en", sram_en, 1'b0);
    check_word("t5_sram_we", {28'h0, sram_we}, 32'h0);
    tick();
    idle();
    #1;
    check_bit("t5_data_ok", p1_data_ok, 1'b1);
    check_bit("t5_err", p1_err, 1'b1);
    check_bit("t5_p0_data_ok", p0_data_ok, 1'b0);
    tick();

    // 6: build the counter to 3, reset with a load in flight.
    drive0(1'b0, 2'd2, 32'h500, 32'h0);
    drive1(1'b0, 2'd2, 32'h40, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      #1;
      check_bit($sformatf("t6_pre_addr_ok_c%0d", c), p0_addr_ok, 1'b1);
      tick();
    end
    reset = 1'b1;
    #1;
    check_bit("t6_rst_data_ok", p0_data_ok, 1'b0);
    check_bit("t6_rst_addr_ok", p0_addr_ok, 1'b0);
    check_bit("t6_rst_sram_en", sram_en, 1'b0);
    tick();
    #1;
    check_bit("t6_rst_data_ok2", p0_data_ok, 1'b0);
    tick();
    reset = 1'b0;
    // A cleared counter gives p0 four more wins before p1 is forced.
    for (int c = 1; c <= 5; c++) begin
      #1;
      check_bit($sformatf("t6_post_p0_addr_ok_c%0d", c), p0_addr_ok, c != 5);
      check_bit($sformatf("t6_post_p1_addr_ok_c%0d", c), p1_addr_ok, c == 5);
      if (c == 2) check_bit("t6_first_data_ok", p0_data_ok, 1'b1);
      tick();
    end
    idle();
    #1;
    check_bit("t6_p1_data_ok", p1_data_ok, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
